uart_rx_core: RTL

//  Parametrised UART receive core. It is the next generation of the Bluetooth serial receiver.

---
 rtl/uart_rx_core_pkg.sv | 20 ++
 rtl/uart_rx_core_rx_sync.sv | 19 +
 rtl/uart_rx_core.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive core: FSM states, parity modes, baud helpers.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous serial line.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Resets to 1 so a line held in reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: glitch-filtered start detect, configurable framing, one-entry holder.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB  = cycles_per_bit(CLK_HZ, BAUD);
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int MID  = CPB / 2 - 1;
  localparam int LAST = CPB - 1;

  logic rx_s, rx_prev_q, fall;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_prev_q <= 1'b1;
    else      rx_prev_q <= rx_s;
  end

  assign fall = rx_prev_q & ~rx_s;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done, bit_tick;

  assign bit_tick = (cnt_q == CW'(LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = ST_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        // Restart the counter at mid start bit so every later tick lands mid-bit.
        if (cnt_q == CW'(MID)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          perr_d  = (^shift_q) ^ rx_s ^ (PARITY == PARITY_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!rx_s) ferr_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  logic [DATA_BITS-1:0] data_q;
  logic                 dv_q, pe_q, fe_q, ov_q, hs;

  assign hs = dv_q & data_ready;

  // A frame completing while the holder is full and unaccepted is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      dv_q   <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      if (done && (!dv_q || data_ready)) begin
        data_q <= shift_q;
        pe_q   <= perr_q;
        fe_q   <= ferr_d;
        dv_q   <= 1'b1;
      end else if (hs) begin
        dv_q <= 1'b0;
      end
      if (hs)                ov_q <= 1'b0;
      else if (done && dv_q) ov_q <= 1'b1;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
